player_health_controller: RTL and testbench
===========================================

// Module: player_health_controller
// PURPOSE
//  Consumes enemy_attack pulses from the enemy controller and tracks player health.
//  Applies invulnerability frames (i-frames) after each hit and drives a screen damage-flash strobe.
//  Owns the game-level IDLE/PLAYING/DEAD state consumed by the renderer and HUD.
//  Sits directly downstream of enemy_controller, alongside weapon_controller.
// PARAMETERS
//  HW            3  width of health counter
//  MAX_HEALTH    5  health loaded on reset/restart (must be < 2**HW)
//  IFRAME_TICKS  6  slow_tick periods of invulnerability after a hit (~2 s)
//  FLASH_TICKS   2  slow_tick periods damage_flash stays high
// PORTS
//  clk            in   1   system clock (only clock)
//  rst_n          in   1   asynchronous, active-low reset
//  slow_tick      in   1   1-clk enable pulse, ~3 Hz, synchronous to clk
//  start          in   1   start/restart request (level or pulse, sampled each clk)
//  enemy_attack   in   1   attack strobe from enemy_controller
//  heal           in   1   1-clk pickup pulse, +1 health
//  player_health  out  HW  current health
//  game_state     out  3   001 IDLE, 010 PLAYING, 100 DEAD (one-hot)
//  damage_flash   out  1   high while flash counter nonzero
//  invulnerable   out  1   high while i-frame counter nonzero
//  game_over      out  1   high in DEAD
// BEHAVIOUR
//  Reset (rst_n=0, async): game_state=IDLE, player_health=MAX_HEALTH, damage_flash=0,
//   invulnerable=0, game_over=0, both counters=0, attack edge register=0.
//  Hit detect: hit = enemy_attack & ~attack_q. attack_q registers every clk in every state,
//   so a level held high counts once and a level already high on entry to PLAYING never hits.
//  IDLE: health held at MAX_HEALTH; start=1 -> PLAYING next clk.
//  PLAYING, per clk, in this priority order:
//   - hit && iframe_cnt==0:
//     - health==1 -> health=0, state=DEAD next clk.
//     - else health-1, iframe_cnt=IFRAME_TICKS, flash_cnt=FLASH_TICKS.
//     - heal in the same clk is dropped (hit wins).
//   - hit && iframe_cnt!=0: ignored entirely (no health change, no flash reload).
//   - heal (no hit): health+1, saturating at MAX_HEALTH.
//   - slow_tick: iframe_cnt and flash_cnt decrement if nonzero, saturating at 0.
//     A load in the same clk wins over the decrement.
//  Latency: hit -> player_health/damage_flash/invulnerable update on the next clk edge (1 cycle).
//  DEAD: game_over=1, health=0, counters cleared, hits/heals ignored.
//   start=1 -> PLAYING with health=MAX_HEALTH and counters 0.
//  start while PLAYING: ignored.
//  All outputs are registered; no combinational input->output paths.
//  Unused game_state encodings recover to IDLE.
// STRUCTURE
//  doom_pkg holds the shared encodings:
//   - game_state (IDLE/PLAYING/DEAD)
//   - fire_state FIRING=3'b010
//   - camera_view FWD=001/LEFT=011/RIGHT=110
//  Sub-module tick_down_counter #(W): load/value/tick inputs, zero-saturating decrement,
//   load priority; nonzero flag output. Instantiated twice (i-frame counter, flash counter).
//  Top level holds the FSM, edge detect and health arithmetic.
// TESTING
//  1 reset, start, then enemy_attack high 1 clk
//    -> health 5->4 next clk; damage_flash=1 and invulnerable=1;
//       flash clears after 2 slow_ticks, invulnerable after 6.
//  2 second attack 3 slow_ticks after the first -> ignored, health stays 4;
//    attack after 6 slow_ticks -> 3.
//  3 enemy_attack held high 20 clks with i-frames expired mid-hold -> exactly one decrement.
//  4 heal at health 5 -> stays 5; heal+hit same clk at health 4 -> 3, not 4.
//  5 five spaced hits -> health 0, game_state=100, game_over=1;
//    start -> game_state=010, health=5.
//  6 rst_n low mid-flash in PLAYING -> all outputs at reset values immediately, without a clk edge.

Source files
------------

// File: rtl/doom_pkg.sv
// Purpose : shared encodings for the game-level controllers (game state, fire state, camera view).
// Latency : n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   game_state_e   one-hot game state consumed by renderer/HUD (IDLE/PLAYING/DEAD)
//   FIRE_FIRING    weapon_controller firing-state code
//   camera_view_e  camera direction codes
//   gs_is_legal    true for the three legal one-hot game-state codes
package doom_pkg;

  typedef enum logic [2:0] {
    GS_IDLE    = 3'b001,
    GS_PLAYING = 3'b010,
    GS_DEAD    = 3'b100
  } game_state_e;

  localparam logic [2:0] FIRE_FIRING = 3'b010;

  typedef enum logic [2:0] {
    CAM_FWD   = 3'b001,
    CAM_LEFT  = 3'b011,
    CAM_RIGHT = 3'b110
  } camera_view_e;

  function automatic logic gs_is_legal(input logic [2:0] s);
    return (s == GS_IDLE) || (s == GS_PLAYING) || (s == GS_DEAD);
  endfunction

endpackage

// File: rtl/tick_down_counter.sv
// Purpose : loadable down-counter that decrements once per tick enable and sticks at zero.
// Latency : load/tick take effect on the next clk edge; nonzero reflects the registered count.
// Backpressure: none; a load in the same clk as a tick wins over the decrement.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset (count resets to 0)
//   load        load load_val this clk (takes priority over tick)
//   load_val    W-bit value to load
//   tick        decrement enable; ignored when the count is already 0
//   nonzero     high while the registered count is nonzero
module tick_down_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         nonzero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign nonzero = |cnt_q;

endmodule

// File: rtl/player_health_controller.sv
// Purpose : tracks player health from enemy attack edges, runs i-frames and damage flash, owns IDLE/PLAYING/DEAD.
// Latency : 1 clk from an accepted hit/heal/start to every output; all outputs come from flops.
// Backpressure: none; attack edges during i-frames and all hits/heals outside PLAYING are dropped.
//
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   slow_tick       ~3 Hz one-clk enable that paces the i-frame and flash counters
//   start           start/restart request, level or pulse (ignored while PLAYING)
//   enemy_attack    attack strobe; only the rising edge counts as a hit
//   heal            one-clk pickup pulse, +1 health saturating at MAX_HEALTH
//   player_health   current health
//   game_state      one-hot 001 IDLE / 010 PLAYING / 100 DEAD
//   damage_flash    high while the flash counter is nonzero
//   invulnerable    high while the i-frame counter is nonzero
//   game_over       high in DEAD
module player_health_controller
  import doom_pkg::*;
#(
  parameter int HW           = 3,
  parameter int MAX_HEALTH   = 5,
  parameter int IFRAME_TICKS = 6,
  parameter int FLASH_TICKS  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          slow_tick,
  input  logic          start,
  input  logic          enemy_attack,
  input  logic          heal,
  output logic [HW-1:0] player_health,
  output logic [2:0]    game_state,
  output logic          damage_flash,
  output logic          invulnerable,
  output logic          game_over
);

  localparam int IW = $clog2(IFRAME_TICKS + 1);
  localparam int FW = $clog2(FLASH_TICKS + 1);

  localparam logic [HW-1:0] HEALTH_MAX = HW'(MAX_HEALTH);
  localparam logic [HW-1:0] HEALTH_ONE = HW'(1);

  game_state_e   state_q;
  game_state_e   state_d;
  logic [HW-1:0] health_q;
  logic [HW-1:0] health_d;
  logic          attack_q;
  logic          attack_d;

  logic          hit;
  logic          hit_taken;
  logic          lethal;
  logic          arm;
  logic          cnt_clr;
  logic          iframe_nz;
  logic          flash_nz;
  logic          iframe_load;
  logic [IW-1:0] iframe_val;
  logic          flash_load;
  logic [FW-1:0] flash_val;

  // Edge detect and hit qualification. attack_q follows the input in every
  // state, so a level that is already high when PLAYING begins never hits.
  always_comb begin
    attack_d  = enemy_attack;
    hit       = enemy_attack & ~attack_q;
    hit_taken = (state_q == GS_PLAYING) && hit && !iframe_nz;
    lethal    = hit_taken && (health_q <= HEALTH_ONE);
    // A lethal hit goes straight to DEAD without arming i-frames/flash.
    arm       = hit_taken && !lethal;
  end

  // Counters are held at zero outside PLAYING; that also gives a restart
  // from DEAD clean counters without a separate clear port.
  always_comb begin
    cnt_clr     = (state_q != GS_PLAYING);
    iframe_load = cnt_clr | arm;
    iframe_val  = arm ? IW'(IFRAME_TICKS) : '0;
    flash_load  = cnt_clr | arm;
    flash_val   = arm ? FW'(FLASH_TICKS) : '0;
  end

  tick_down_counter #(.W(IW)) u_iframe_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (iframe_load),
    .load_val (iframe_val),
    .tick     (slow_tick),
    .nonzero  (iframe_nz)
  );

  tick_down_counter #(.W(FW)) u_flash_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (flash_load),
    .load_val (flash_val),
    .tick     (slow_tick),
    .nonzero  (flash_nz)
  );

  // Health arithmetic. An attack edge during i-frames still blocks a heal in
  // the same clk: heal only applies on a clk with no attack edge at all.
  always_comb begin
    health_d = health_q;
    case (state_q)
      GS_IDLE: begin
        health_d = HEALTH_MAX;
      end
      GS_PLAYING: begin
        if (hit_taken) begin
          health_d = health_q - HEALTH_ONE;
        end else if (!hit && heal && (health_q < HEALTH_MAX)) begin
          health_d = health_q + HEALTH_ONE;
        end
      end
      GS_DEAD: begin
        health_d = start ? HEALTH_MAX : '0;
      end
      default: begin
        health_d = HEALTH_MAX;
      end
    endcase
  end

  // FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= GS_IDLE;
      health_q <= HEALTH_MAX;
      attack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      health_q <= health_d;
      attack_q <= attack_d;
    end
  end

  // FSM: next state. Any non one-hot code falls back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      GS_IDLE:    if (start)  state_d = GS_PLAYING;
      GS_PLAYING: if (lethal) state_d = GS_DEAD;
      GS_DEAD:    if (start)  state_d = GS_PLAYING;
      default:    state_d = GS_IDLE;
    endcase
  end

  // FSM: outputs, all taken straight from flops.
  always_comb begin
    game_state    = state_q;
    game_over     = gs_is_legal(state_q) && (state_q == GS_DEAD);
    player_health = health_q;
    damage_flash  = flash_nz;
    invulnerable  = iframe_nz;
  end

endmodule

// File: tb/tb_player_health_controller.sv
// Purpose : self-checking bench for player_health_controller: vector table, corner sequences, random vs model.
// Latency : inputs are applied just after a rising edge and outputs sampled 1 time unit after the next one.
// Backpressure: n/a.
module tb_player_health_controller;

  localparam int HW   = 3;
  localparam int MAXH = 5;
  localparam int IFT  = 6;
  localparam int FLT  = 2;
  localparam int S_I  = 1;
  localparam int S_P  = 2;
  localparam int S_D  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          slow_tick;
  logic          start;
  logic          enemy_attack;
  logic          heal;
  logic [HW-1:0] player_health;
  logic [2:0]    game_state;
  logic          damage_flash;
  logic          invulnerable;
  logic          game_over;

  int n_pass  = 0;
  int n_total = 0;

  player_health_controller #(
    .HW(HW), .MAX_HEALTH(MAXH), .IFRAME_TICKS(IFT), .FLASH_TICKS(FLT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .slow_tick     (slow_tick),
    .start         (start),
    .enemy_attack  (enemy_attack),
    .heal          (heal),
    .player_health (player_health),
    .game_state    (game_state),
    .damage_flash  (damage_flash),
    .invulnerable  (invulnerable),
    .game_over     (game_over)
  );

  always #5 clk = ~clk;

  // Vector record: inputs packed {start, enemy_attack, heal, slow_tick},
  // expected outputs packed as built by e().
  typedef struct {
    logic [3:0]  in;
    logic [31:0] exp;
  } vec_t;

  vec_t vq[$];

  // Behavioural reference: plain integers for state, health and counters.
  int m_state;  // 0 idle, 1 playing, 2 dead
  int m_h;
  int m_ifr;
  int m_fl;
  bit m_prev;

  function automatic logic [31:0] e(input int h, input int gs, input int f, input int i, input int o);
    return 32'(h * 64 + gs * 8 + f * 4 + i * 2 + o);
  endfunction

  function automatic logic [31:0] outs();
    return 32'({player_health, game_state, damage_flash, invulnerable, game_over});
  endfunction

  function automatic void add(input logic [3:0] in, input logic [31:0] exp);
    vec_t v;
    v.in  = in;
    v.exp = exp;
    vq.push_back(v);
  endfunction

  function automatic void model_reset();
    m_state = 0;
    m_h     = MAXH;
    m_ifr   = 0;
    m_fl    = 0;
    m_prev  = 1'b0;
  endfunction

  function automatic void model_clk(input logic [3:0] c);
    bit hit;
    bit loaded;
    hit    = c[2] && !m_prev;
    loaded = 1'b0;
    m_prev = c[2];
    if (m_state == 0) begin
      m_h = MAXH;
      if (c[3]) m_state = 1;
    end else if (m_state == 1) begin
      if (hit && m_ifr == 0) begin
        if (m_h == 1) begin
          m_h     = 0;
          m_state = 2;
        end else begin
          m_h    = m_h - 1;
          m_ifr  = IFT;
          m_fl   = FLT;
          loaded = 1'b1;
        end
      end else if (!hit && c[1]) begin
        m_h = (m_h + 1 > MAXH) ? MAXH : m_h + 1;
      end
      if (c[0] && !loaded) begin
        if (m_ifr > 0) m_ifr = m_ifr - 1;
        if (m_fl > 0)  m_fl  = m_fl - 1;
      end
    end else begin
      m_ifr = 0;
      m_fl  = 0;
      if (c[3]) begin
        m_state = 1;
        m_h     = MAXH;
      end else begin
        m_h = 0;
      end
    end
  endfunction

  function automatic logic [31:0] model_outs();
    int gs;
    gs = (m_state == 0) ? S_I : (m_state == 1) ? S_P : S_D;
    return e(m_h, gs, (m_fl > 0) ? 1 : 0, (m_ifr > 0) ? 1 : 0, (m_state == 2) ? 1 : 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] c);
    {start, enemy_attack, heal, slow_tick} = c;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(4'b0000);
    step();
    step();
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [3:0] c;
    logic       a_lvl;

    do_reset();
    chk("reset_outputs", outs(), e(5, S_I, 0, 0, 0));

    // Vector table: IDLE hold, start with attack already high, then the
    // single-hit / i-frame / heal / heal-vs-hit story.
    add(4'b0100, e(5, S_I, 0, 0, 0));            // attack in IDLE: no effect
    add(4'b1100, e(5, S_P, 0, 0, 0));            // start while attack level high
    add(4'b0000, e(5, S_P, 0, 0, 0));
    add(4'b0100, e(4, S_P, 1, 1, 0));            // first hit
    add(4'b0001, e(4, S_P, 1, 1, 0));            // tick 1
    add(4'b0001, e(4, S_P, 0, 1, 0));            // tick 2: flash clears
    add(4'b0001, e(4, S_P, 0, 1, 0));            // tick 3
    add(4'b0100, e(4, S_P, 0, 1, 0));            // hit during i-frames ignored
    add(4'b0001, e(4, S_P, 0, 1, 0));            // tick 4
    add(4'b0001, e(4, S_P, 0, 1, 0));            // tick 5
    add(4'b0001, e(4, S_P, 0, 0, 0));            // tick 6: invulnerable clears
    add(4'b0100, e(3, S_P, 1, 1, 0));            // second accepted hit
    add(4'b0010, e(4, S_P, 1, 1, 0));            // heal
    add(4'b0010, e(5, S_P, 1, 1, 0));            // heal to max
    add(4'b0010, e(5, S_P, 1, 1, 0));            // heal at max saturates
    add(4'b0001, e(5, S_P, 1, 1, 0));
    add(4'b0001, e(5, S_P, 0, 1, 0));
    for (int k = 0; k < 3; k++) add(4'b0001, e(5, S_P, 0, 1, 0));
    add(4'b0001, e(5, S_P, 0, 0, 0));
    add(4'b0100, e(4, S_P, 1, 1, 0));            // hit at 5 -> 4
    add(4'b0001, e(4, S_P, 1, 1, 0));
    add(4'b0001, e(4, S_P, 0, 1, 0));
    for (int k = 0; k < 3; k++) add(4'b0001, e(4, S_P, 0, 1, 0));
    add(4'b0001, e(4, S_P, 0, 0, 0));
    add(4'b0110, e(3, S_P, 1, 1, 0));            // heal+hit same clk: hit wins
    add(4'b1000, e(3, S_P, 1, 1, 0));            // start while PLAYING ignored

    foreach (vq[k]) begin
      drive(vq[k].in);
      step();
      chk($sformatf("vec%0d", k), outs(), vq[k].exp);
    end

    // Attack held for 20 clks while i-frames run out: one decrement only.
    for (int k = 0; k < 6; k++) begin
      drive(4'b0001);
      step();
    end
    chk("hold_pre_invuln", 32'(invulnerable), 32'd0);
    for (int k = 0; k < 20; k++) begin
      drive({2'b01, 1'b0, (k >= 1 && k <= 8) ? 1'b1 : 1'b0});
      step();
      if (k == 0) chk("hold_first_hit", 32'(player_health), 32'd2);
    end
    chk("hold_single_decrement", 32'(player_health), 32'd2);
    chk("hold_iframes_expired", 32'(invulnerable), 32'd0);
    drive(4'b0000);
    step();

    // Five spaced hits to death, then restart.
    do_reset();
    drive(4'b1000);
    step();
    for (int k = 1; k <= 5; k++) begin
      drive(4'b0100);
      step();
      chk($sformatf("death_hit%0d_health", k), 32'(player_health), 32'(5 - k));
      if (k == 5) chk("death_state_next_clk", 32'(game_state), 32'(S_D));
      for (int t = 0; t < 6; t++) begin
        drive(4'b0001);
        step();
      end
    end
    chk("dead_outputs", outs(), e(0, S_D, 0, 0, 1));
    drive(4'b0110);
    step();
    chk("dead_ignores_hit_heal", outs(), e(0, S_D, 0, 0, 1));
    drive(4'b1000);
    step();
    chk("restart_outputs", outs(), e(5, S_P, 0, 0, 0));
    drive(4'b0000);
    step();

    // Asynchronous reset mid-flash, checked before any further clk edge.
    do_reset();
    drive(4'b1000);
    step();
    drive(4'b0100);
    step();
    drive(4'b0000);
    chk("pre_reset_flash", 32'(damage_flash), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_no_edge", outs(), e(5, S_I, 0, 0, 0));
    step();
    rst_n = 1'b1;

    // Random stimulus against the reference model.
    do_reset();
    a_lvl = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(3) == 0) a_lvl = ~a_lvl;
      c = {($urandom_range(59) == 0) ? 1'b1 : 1'b0,
           a_lvl,
           ($urandom_range(7) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(2) == 0) ? 1'b1 : 1'b0};
      model_clk(c);
      drive(c);
      step();
      chk($sformatf("rand%0d", n), outs(), model_outs());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
